// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared types, width codes and FSM states for the load/store sequencer
package load_store_unit_pkg;

    typedef logic [31:0] Addr;
    typedef logic [31:0] Data;
    typedef logic        Bool;
    typedef logic        Clock;

    localparam logic [2:0] MW_B  = 3'b000;
    localparam logic [2:0] MW_H  = 3'b001;
    localparam logic [2:0] MW_W  = 3'b010;
    localparam logic [2:0] MW_BU = 3'b100;
    localparam logic [2:0] MW_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} LsuState;

    // Access size in bytes; 0 marks a width code that is never legal.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        return (funct3 == MW_B || funct3 == MW_BU) ? 3'd1 :
               (funct3 == MW_H || funct3 == MW_HU) ? 3'd2 :
               (funct3 == MW_W)                    ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_align.sv
// byte_lane_align: maps access bytes onto the little-endian lanes of one memory word
module byte_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0] offset,
    input  logic [2:0] size,
    input  logic       word_sel,
    input  Data        old_word,
    input  Data        store_data,
    output Data        merged,
    output Data        load_bytes
);

    // Lane j of this word holds access byte k = j + 4*word_sel - offset when 0 <= k < size.
    always_comb begin
        int k;
        merged = old_word;
        load_bytes = '0;
        k = 0;
        for (int j = 0; j < 4; j++) begin
            k = j + 4 * int'(word_sel) - int'(offset);
            if (k >= 0 && k < int'(size)) begin
                merged[8*j +: 8] = store_data[8*k +: 8];
                load_bytes[8*k +: 8] = old_word[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I loads/stores into word accesses with split and read-modify-write
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_idx,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    LsuState    state;
    logic       wr;
    logic [2:0] f3;
    Addr        addr;
    Data        wdata, hold, merged, load_bytes, assembled, extended, load_result;
    logic [2:0] size;
    logic       split, access, bad;
    Addr        base;

    assign size = access_size(f3);
    assign split = ({1'b0, addr[1:0]} + size) > 3'd4;
    assign access = state == FIRST || state == SECOND;
    assign base = {addr[31:2], 2'b00};
    assign bad = access_size(req_funct3) == 3'd0 || (req_write && req_funct3[2]);
    assign req_ready = state == IDLE && !reset;
    assign mem_idx = state == FIRST ? base : state == SECOND ? base + 32'd4 : '0;
    assign mem_write_data = (access && wr) ? merged : '0;
    assign mem_write_enable = access && wr && !reset;
    assign assembled = state == SECOND ? (hold | load_bytes) : load_bytes;
    assign extended = f3 == MW_B ? {{24{assembled[7]}}, assembled[7:0]} :
                      f3 == MW_H ? {{16{assembled[15]}}, assembled[15:0]} : assembled;
    assign load_result = wr ? '0 : extended;

    byte_lane_align u_align (
        .offset     (addr[1:0]),
        .size       (size),
        .word_sel   (state == SECOND),
        .old_word   (mem_read_data),
        .store_data (wdata),
        .merged     (merged),
        .load_bytes (load_bytes)
    );

    // Request FSM: latch on handshake, one or two word accesses, then a one-cycle registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            hold <= '0;
            wr <= 1'b0;
            f3 <= '0;
            addr <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr <= req_write;
                    f3 <= req_funct3;
                    addr <= req_addr;
                    wdata <= req_wdata;
                    state <= bad ? RESP : FIRST;
                    resp_valid <= bad;
                    resp_error <= bad;
                end
                FIRST: begin
                    hold <= assembled;
                    state <= split ? SECOND : RESP;
                    resp_valid <= !split;
                    resp_rdata <= split ? '0 : load_result;
                end
                SECOND: begin
                    state <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_result;
                end
                RESP: begin
                    state <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random checks of load_store_unit against a byte-array memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_idx;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [256];
    logic [31:0] log_idx [4096];
    logic [31:0] log_data [4096];
    logic [7:0]  ref_mem [1024];
    logic        preload = 1'b0;
    int          wr_count = 0;
    int          passed = 0;
    int          total = 0;
    int          last_base;
    logic [31:0] last_rdata;

    load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_idx          (mem_idx),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_idx[9:2]];

    function automatic logic [31:0] pattern(input int i);
        logic [7:0] b;
        b = i[7:0];
        return i == 0 ? 32'hAABBCCDD : i == 1 ? 32'h11223344 : {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Data memory: word write on posedge, plus a bulk preload and a log of every write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (mem_write_enable) begin
            mem[mem_idx[9:2]] <= mem_write_data;
            log_idx[wr_count[11:0]] <= mem_idx;
            log_data[wr_count[11:0]] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    function automatic logic [31:0] ref_word(input logic [7:0] wi);
        return {ref_mem[{wi, 2'd3}], ref_mem[{wi, 2'd2}], ref_mem[{wi, 2'd1}], ref_mem[{wi, 2'd0}]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic do_preload();
        logic [31:0] w;
        @(negedge clk);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        for (int i = 0; i < 256; i++) begin
            w = pattern(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
    endtask

    // One request: the model derives size, legality, latency, write count and data from byte rules.
    task automatic do_op(input string name, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        int sz, exp_lat, exp_writes, c;
        logic ill;
        logic [31:0] exp_data, ba;
        logic [7:0] wi;
        sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : f3 == 3'b010 ? 4 : 0;
        ill = sz == 0 || (w && f3[2]);
        exp_lat = ill ? 1 : (int'(a[1:0]) + sz > 4 ? 3 : 2);
        exp_writes = (ill || !w) ? 0 : exp_lat - 1;
        exp_data = '0;
        if (!ill) begin
            for (int i = 0; i < sz; i++) begin
                ba = a + 32'(i);
                if (w) ref_mem[ba[9:0]] = wd[8*i +: 8];
                else exp_data[8*i +: 8] = ref_mem[ba[9:0]];
            end
            if (!w && f3 == 3'b000 && exp_data[7]) exp_data = exp_data | 32'hFFFFFF00;
            if (!w && f3 == 3'b001 && exp_data[15]) exp_data = exp_data | 32'hFFFF0000;
        end
        @(negedge clk);
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        last_base = wr_count;
        check({name, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        c = 1;
        while (!resp_valid && c < 8) begin
            @(posedge clk);
            #1 c++;
        end
        last_rdata = resp_rdata;
        check({name, " latency"}, resp_valid ? 32'(c) : 32'd0, 32'(exp_lat));
        check({name, " rdata"}, resp_rdata, exp_data);
        check({name, " error"}, 32'(resp_error), 32'(ill));
        check({name, " writes"}, 32'(wr_count - last_base), 32'(exp_writes));
        @(posedge clk);
        #1;
        check({name, " resp drop"}, {31'd0, resp_valid} | resp_rdata, 32'd0);
        check({name, " idle ready"}, 32'(req_ready), 32'd1);
        wi = a[9:2];
        check({name, " word0"}, mem[wi], ref_word(wi));
        wi = wi + 8'd1;
        check({name, " word1"}, mem[wi], ref_word(wi));
    endtask

    initial begin
        int pre;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'd0);
        check("reset resp", {29'd0, resp_valid, resp_error, mem_write_enable}, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset idx", mem_idx, 32'd0);
        check("reset wdata", mem_write_data, 32'd0);
        do_preload();
        @(negedge clk);
        reset = 1'b0;
        #1 check("ready after reset", 32'(req_ready), 32'd1);

        do_op("LW 4", 1'b0, 3'b010, 32'h4, 32'h0);
        check("LW 4 value", last_rdata, 32'h11223344);

        do_preload();
        do_op("SB 6", 1'b1, 3'b000, 32'h6, 32'h000000AA);
        check("SB 6 idx", log_idx[last_base[11:0]], 32'h4);
        check("SB 6 data", log_data[last_base[11:0]], 32'h11AA3344);

        do_preload();
        do_op("LB 3", 1'b0, 3'b000, 32'h3, 32'h0);
        check("LB 3 value", last_rdata, 32'hFFFFFFAA);
        do_op("LBU 3", 1'b0, 3'b100, 32'h3, 32'h0);
        check("LBU 3 value", last_rdata, 32'h000000AA);
        do_op("LH 3", 1'b0, 3'b001, 32'h3, 32'h0);
        check("LH 3 value", last_rdata, 32'h000044AA);

        do_preload();
        do_op("SW 2", 1'b1, 3'b010, 32'h2, 32'hCAFEF00D);
        check("SW 2 idx0", log_idx[last_base[11:0]], 32'h0);
        check("SW 2 data0", log_data[last_base[11:0]], 32'hF00DCCDD);
        check("SW 2 idx1", log_idx[(last_base + 1) % 4096], 32'h4);
        check("SW 2 data1", log_data[(last_base + 1) % 4096], 32'h1122CAFE);

        do_preload();
        do_op("bad load 011", 1'b0, 3'b011, 32'h4, 32'h0);
        do_op("bad store 100", 1'b1, 3'b100, 32'h4, 32'h12345678);
        do_op("LW wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        do_op("SH wrap", 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);

        do_preload();
        @(negedge clk);
        req_write = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h2;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        pre = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check("rst mid resp", 32'(resp_valid), 32'd0);
        check("rst mid ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("rst drop ready", 32'(req_ready), 32'd1);
        check("rst writes", 32'(wr_count - pre), 32'd1);
        check("rst word0", mem[0], 32'hF00DCCDD);
        check("rst word1", mem[1], 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("rst no resp", 32'(resp_valid), 32'd0);
        end
        ref_mem[2] = 8'h0D;
        ref_mem[3] = 8'hF0;

        for (int n = 0; n < 150; n++) begin
            do_op("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
